board_loader: RTL and testbench
===============================

# board_loader

Serial pattern loader that fills the 8x8 Life board's row storage before a run. It accepts one cell bit per handshake on a valid/ready stream and assembles each row in a shift register. It emits one row write per completed row, in row order, to the same row storage that the generation engine and display scan read from. When the last row is written it issues a single-cycle `done` pulse so the controller can begin generations.

## Interface
- `ROWS`, default 8: number of board rows written per load.
- `COLS`, default 8: cells per row, which is also the `wr_data` width.
- `ph1`  in  1: the block's single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; forces every state element and output to its reset value.
- `start`  in  1: level-sampled; begins a load when the block is idle.
- `in_valid`  in  1: `in_bit` holds a cell bit.
- `in_bit`  in  1: cell value, 1 = live.
- `in_ready`  out  1: block accepts a bit this cycle.
- `wr_en`  out  1: single-cycle row write strobe.
- `wr_addr`  out  $clog2(ROWS): row index being written.
- `wr_data`  out  COLS: row contents; bit k is column k.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: single-cycle pulse after the final row write.
- `err`  out  1: sticky error flag; only meaningful with parity compiled in.

## Operation
- Four states: IDLE, SHIFT, WRITE, DONE.
- Reset values:
  - State is IDLE.
  - `in_ready`, `wr_en`, `busy`, `done`, `err` = 0.
  - `wr_addr` = 0, `wr_data` = 0, row index = 0, bit count = 0.
- IDLE:
  - `in_ready` = 0.
  - `start` = 1 moves to SHIFT, clears the row index, the bit count and `err`.
- SHIFT:
  - `in_ready` = 1.
  - A bit is accepted only when `in_valid` and `in_ready` are both high.
  - The n-th accepted bit of a row goes to column n, LSB first.
  - When the bit count reaches the row length (COLS, or COLS+1 with parity), move to WRITE and clear the count.
  - Cycles with `in_valid` low stall in SHIFT with no other effect.
- WRITE:
  - `in_ready` = 0.
  - `wr_en` = 1 for exactly one cycle.
  - `wr_addr` = row index; `wr_data` = the assembled row.
  - If the row index is ROWS-1, go to DONE. Otherwise increment the row index and return to SHIFT.
- DONE:
  - `done` = 1 for one cycle, then return to IDLE.
  - `wr_addr` and `wr_data` keep their last values until the next write.
- `start` is ignored in every state except IDLE. The only way to abort a load is `reset`.
- An asserted `reset` mid-load discards any partial row. No `wr_en` or `done` is produced afterward until a new `start`.
- The row index never wraps within a load. A partial board is never committed as complete.

## Timing
- Call the cycle in which `start` is sampled in IDLE cycle 0. `in_ready` rises in cycle 1.
- With `in_valid` held high and parity compiled out:
  - Row r is written in cycle 9(r+1).
  - The last write lands in cycle 72; `done` pulses in cycle 73.
  - `busy` is high in cycles 1 through 73.
- With parity compiled in, each row takes COLS+1 accept cycles:
  - Row r is written in cycle 10(r+1).
  - `done` pulses in cycle 81.
- Latency from the last accepted bit of a row to its `wr_en` is 1 cycle.
- `in_ready` is low during WRITE, DONE and IDLE. A producer holding `in_valid` high across those cycles loses no bits.

## Configuration
- Macro: `BOARD_LOADER_PARITY_EN`.
- Defined:
  - Each row carries one extra trailing bit, making the count of ones over the COLS+1 bits odd.
  - On a parity mismatch the WRITE cycle still occurs and the row index still advances, but `wr_en` stays 0 and `err` is set.
  - `err` stays set until the next accepted `start` or `reset`.
  - `done` still pulses at the end of the load.
- Undefined:
  - Rows are exactly COLS bits.
  - `err` is tied to 0.

## Test plan
- Glider load, parity off, continuous `in_valid`:
  - Stimulus: rows 0x02, 0x04, 0x07, then 0x00 for rows 3-7, sent LSB first.
  - Required: `wr_en` in cycles 9, 18, …, 72 with `wr_addr` 0-7 and matching data; `done` only in cycle 73.
- Stalls: drop `in_valid` for 3 cycles mid-row 2 -> row 2 write delayed by exactly 3 cycles, data unchanged, later rows shift by 3.
- Ignored start: assert `start` during SHIFT of row 4 -> no restart; rows 4-7 are written normally.
- Mid-load reset: assert `reset` asynchronously after row 5's third bit -> all outputs 0 immediately; no `wr_en` or `done` until the next `start`.
- Parity on: the row 3 parity bit is wrong -> no `wr_en` in cycle 40; `err` = 1 from cycle 40; `done` in cycle 81; the next `start` clears `err`.
- Parity on, all-zero board with parity bits = 1 -> 8 writes of 0x00, `err` stays 0.

Source files
------------

// File: rtl/board_loader.sv
// Serial 8x8 Life pattern loader: one cell bit per valid/ready beat, one row write per completed row, then a done pulse.
// Latency: a row's wr_en follows its last accepted bit by 1 cycle. Backpressure: in_ready is high only while a row is being shifted in.
// Build option BOARD_LOADER_PARITY_EN adds a trailing odd-parity bit per row; bad rows are dropped and flag err.
module board_loader #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                    ph1,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic                    in_bit,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_addr,
    output logic [COLS-1:0]         wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

`ifdef BOARD_LOADER_PARITY_EN
    localparam int LEN = COLS + 1;
`else
    localparam int LEN = COLS;
`endif
    localparam int CW = $clog2(LEN + 1);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [RW-1:0]   row_idx;
    logic [COLS-1:0] row_sr;
    logic [COLS-1:0] row_nxt;
    logic            accept;
    logic            row_end;
    logic            row_ok;

    assign accept  = in_valid && (state == SHIFT);
    assign row_end = accept && (bit_cnt == CW'(LEN - 1));

`ifdef BOARD_LOADER_PARITY_EN
    logic par_acc;
    logic par_nxt;
    logic row_ok_q;
    logic err_q;

    // The trailing parity bit is counted but never shifted into the row.
    assign row_nxt = (int'(bit_cnt) < COLS) ? {in_bit, row_sr[COLS-1:1]} : row_sr;
    assign par_nxt = par_acc ^ in_bit;
    assign row_ok  = row_ok_q;
    assign err     = err_q;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            par_acc  <= 1'b0;
            row_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                par_acc <= 1'b0;
                err_q   <= 1'b0;
            end
            if (accept) begin
                par_acc <= row_end ? 1'b0 : par_nxt;
                if (row_end) begin
                    row_ok_q <= par_nxt;
                    if (!par_nxt) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign row_nxt = {in_bit, row_sr[COLS-1:1]};
    assign row_ok  = 1'b1;
    assign err     = 1'b0;
`endif

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                in_ready = 1'b1;
                if (row_end) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = row_ok;
                state_nxt = (row_idx == LAST_ROW) ? DONE : SHIFT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // wr_addr/wr_data are captured as the row completes and held until the next row.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            row_idx <= '0;
            row_sr  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                bit_cnt <= '0;
                row_idx <= '0;
            end
            if (accept) begin
                row_sr <= row_nxt;
                if (row_end) begin
                    bit_cnt <= '0;
                    wr_addr <= row_idx;
                    wr_data <= row_nxt;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == WRITE && row_idx != LAST_ROW) begin
                row_idx <= row_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// Bench for board_loader: directed and randomized loads checked against a cycle-schedule model of the load rules.
module tb_board_loader;
    localparam int ROWS = 8;
    localparam int COLS = 8;
`ifdef BOARD_LOADER_PARITY_EN
    localparam int LEN = COLS + 1;
`else
    localparam int LEN = COLS;
`endif
    localparam int NC = 512;

    logic       ph1 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready, wr_en, busy, done, err;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    board_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .ph1(ph1), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 ph1 = ~ph1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rows [ROWS];
    bit         badpar [ROWS];
    bit         vpat [NC];
    bit         exp_rdy [NC];
    bit         exp_wr [NC];
    bit         exp_err [NC];
    logic [2:0] exp_addr [NC];
    logic [7:0] exp_data [NC];
    bit         stream [ROWS*LEN];
    int         done_cyc;
    int         row4_wr;

    task automatic chk(input string tag, input int c, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, act, exp);
        end
    endtask

    // Producer pattern plus the expected schedule: a row needs LEN valid cycles while in SHIFT,
    // is written the following cycle, and shifting resumes the cycle after that.
    task automatic build_model(input int mode);
        int t, cnt, s;
        bit err_seen;
        for (int i = 0; i < NC; i++) begin
            vpat[i] = (mode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
            exp_rdy[i] = 0; exp_wr[i] = 0; exp_err[i] = 0;
            exp_addr[i] = '0; exp_data[i] = '0;
        end
        if (mode == 1) begin
            s = 2 * (LEN + 1) + 1;
            for (int i = s + 3; i < s + 6; i++) vpat[i] = 1'b0;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) stream[r*LEN+k] = rows[r][k];
            if (LEN > COLS) stream[r*LEN+COLS] = ~(^rows[r]) ^ badpar[r];
        end
        t = 1;
        err_seen = 0;
        row4_wr = 0;
        for (int r = 0; r < ROWS; r++) begin
            cnt = 0;
            while (cnt < LEN && t < NC - 8) begin
                exp_rdy[t] = 1;
                if (vpat[t]) cnt++;
                t++;
            end
            exp_wr[t] = !badpar[r];
            exp_addr[t] = 3'(r);
            exp_data[t] = rows[r];
            if (badpar[r]) err_seen = 1;
            if (r == 4) row4_wr = t;
            for (int i = t; i < NC; i++) exp_err[i] = err_seen;
            t++;
        end
        done_cyc = t;
    endtask

    task automatic run_load(input int mode, input bit extra_start, input int abort_at);
        int idx;
        build_model(mode);
        if (done_cyc >= NC - 8) chk("model_budget", done_cyc, 1, 0);
        idx = 0;
        @(posedge ph1); #1;
        for (int c = 0; c <= done_cyc + 2; c++) begin
            start = (c == 0) || (extra_start && c == row4_wr - 3);
            in_valid = vpat[c];
            in_bit = (idx < ROWS*LEN) ? stream[idx] : 1'b0;
            @(negedge ph1);
            chk("in_ready", c, in_ready, exp_rdy[c]);
            chk("wr_en", c, wr_en, exp_wr[c]);
            if (exp_wr[c]) begin
                chk("wr_addr", c, wr_addr, exp_addr[c]);
                chk("wr_data", c, wr_data, exp_data[c]);
            end
            chk("done", c, done, c == done_cyc);
            chk("busy", c, busy, c >= 1 && c <= done_cyc);
            if (c > 0) chk("err", c, err, exp_err[c]);
            if (in_valid && in_ready) idx++;
            if (abort_at > 0 && idx == abort_at) begin
                @(posedge ph1); #4;
                reset = 1'b1;
                #1;
                chk("rst_in_ready", c, in_ready, 0);
                chk("rst_wr_en", c, wr_en, 0);
                chk("rst_busy", c, busy, 0);
                chk("rst_done", c, done, 0);
                chk("rst_err", c, err, 0);
                chk("rst_wr_addr", c, wr_addr, 0);
                chk("rst_wr_data", c, wr_data, 0);
                @(posedge ph1); #1;
                reset = 1'b0;
                start = 1'b0;
                in_valid = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge ph1);
                    chk("post_rst_wr_en", k, wr_en, 0);
                    chk("post_rst_done", k, done, 0);
                    chk("post_rst_busy", k, busy, 0);
                end
                return;
            end
            @(posedge ph1); #1;
        end
        start = 1'b0;
    endtask

    task automatic set_glider();
        for (int r = 0; r < ROWS; r++) begin
            rows[r] = 8'h00;
            badpar[r] = 0;
        end
        rows[0] = 8'h02; rows[1] = 8'h04; rows[2] = 8'h07;
    endtask

    task automatic set_random();
        for (int r = 0; r < ROWS; r++) begin
            rows[r] = 8'($urandom);
            badpar[r] = 0;
        end
    endtask

    initial begin
        #3;
        chk("reset_in_ready", 0, in_ready, 0);
        chk("reset_wr_en", 0, wr_en, 0);
        chk("reset_busy", 0, busy, 0);
        chk("reset_done", 0, done, 0);
        chk("reset_err", 0, err, 0);
        chk("reset_wr_addr", 0, wr_addr, 0);
        chk("reset_wr_data", 0, wr_data, 0);
        @(negedge ph1);
        reset = 1'b0;
        repeat (2) @(negedge ph1);

        set_glider();
        run_load(0, 0, 0);
        set_glider();
        run_load(1, 0, 0);
        set_glider();
        run_load(0, 1, 0);
        set_random();
        run_load(2, 0, 5*LEN + 3);
        set_random();
        run_load(2, 0, 0);
        set_random();
        run_load(2, 1, 0);
`ifdef BOARD_LOADER_PARITY_EN
        set_glider();
        badpar[3] = 1;
        run_load(0, 0, 0);
        for (int r = 0; r < ROWS; r++) begin
            rows[r] = 8'h00;
            badpar[r] = 0;
        end
        run_load(0, 0, 0);
        set_random();
        badpar[$urandom_range(0, ROWS-1)] = 1;
        run_load(2, 0, 0);
`else
        set_random();
        run_load(1, 0, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
